pc_stack: RTL

Parametrised program counter with a hardware return-address stack, the next-generation replacement for the fixed 16-bit load/inc/reset counter in the memory library. It adds call and return operations backed by a DEPTH-entry LIFO, plus stack status and sticky error flags. It sits between the instruction decoder and the instruction ROM address input. It is single-clock, with all state updated on the rising edge of `clock`.

---
 rtl/pc_stack.sv | 57 +++++
 1 files changed

// File: rtl/pc_stack.sv
// pc_stack: program counter with a DEPTH-entry hardware return-address stack and sticky error flags
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    top;
  logic             push;
  assign pc_inc = out + WIDTH'(1);
  assign empty  = count == '0;
  assign full   = count == CW'(DEPTH);
  assign top    = AW'(count - CW'(1));
  assign push   = call && !ret && !full;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out       <= RESET_VALUE;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ret) begin
        if (!empty) begin
          out   <= stack[top];
          count <= count - CW'(1);
        end
      end else if (call) begin
        out <= in;
        if (!full) count <= count + CW'(1);
      end else if (load) out <= in;
      else if (inc) out <= pc_inc;
      // a new error on the same edge as clear_err wins
      overflow  <= (overflow && !clear_err) || (call && !ret && full);
      underflow <= (underflow && !clear_err) || (ret && empty);
    end
  // storage is not reset; entries above count are don't-care
  always_ff @(posedge clock)
    if (push) stack[count[AW-1:0]] <= pc_inc;
endmodule
